nn_frame_loader: RTL and testbench

- Producer side of the neural_net input interface.
- Accepts a pixel stream one dWidth word per beat over a valid/ready handshake and packs it into the flattened in bus (IN_N*dWidth bits).
- Holds the bus stable, pulses first to launch inference, waits for net completion, then returns the 4-bit class with a valid strobe.
- Replaces the bench-side $readmemb/index driving with synthesizable frame delivery, e.g. from a UART or DMA front end.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/nn_frame_loader_if.sv | 28 ++
 rtl/nn_frame_buf.sv | 19 +
 rtl/nn_frame_loader.sv | 167 ++++++++++++++++
 tb/tb_nn_frame_loader.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared types and sizing for the neural-net frame loader: FSM states, frame geometry,
// and the pixel-to-bus bit mapping.
package nn_pkg;
    localparam int IN_N         = 784;
    localparam int DWIDTH       = 16;
    localparam int RES_W        = 4;
    localparam int FIRST_CYCLES = 2;
    localparam int CNT_W        = $clog2(IN_N);
    localparam int BUS_W        = IN_N * DWIDTH;
    localparam int FC_W         = (FIRST_CYCLES > 1) ? $clog2(FIRST_CYCLES) : 1;

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        WAIT
    } state_t;

    // Pixel 0 sits in the MSBs so the bus matches the file order of the reference frames.
    function automatic int pix_msb(input logic [CNT_W-1:0] k);
        return (IN_N - int'(k)) * DWIDTH - 1;
    endfunction
endpackage

// File: rtl/nn_frame_loader_if.sv
// Pixel stream, frame bus and net result signals between a frame source/net and the loader.
// slave = loader side, master = source/net side.
interface nn_frame_loader_if;
    import nn_pkg::*;

    logic [DWIDTH-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [BUS_W-1:0]  in_bus;
    logic              first;
    logic              net_done;
    logic [RES_W-1:0]  net_result;
    logic [RES_W-1:0]  res_data;
    logic              res_valid;
    logic              frame_err;
    logic              busy;

    modport master (
        output s_data, s_valid, s_last, net_done, net_result,
        input  s_ready, in_bus, first, res_data, res_valid, frame_err, busy
    );

    modport slave (
        input  s_data, s_valid, s_last, net_done, net_result,
        output s_ready, in_bus, first, res_data, res_valid, frame_err, busy
    );
endinterface

// File: rtl/nn_frame_buf.sv
// One flattened frame register; a write stores one pixel word at its packed position.
module nn_frame_buf
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [CNT_W-1:0]  idx,
    input  logic [DWIDTH-1:0] data,
    output logic [BUS_W-1:0]  frame
);
    always_ff @(posedge clk) begin
        if (rst) begin
            frame <= '0;
        end else if (we) begin
            frame[pix_msb(idx) -: DWIDTH] <= data;
        end
    end
endmodule

// File: rtl/nn_frame_loader.sv
// Packs a pixel stream into the neural_net input bus, launches inference and returns the class.
// NN_FRAME_LOADER_DBUF_EN: ping/pong buffers so the next frame streams in while the net runs.
//
// state  | meaning
// FILL   | accepting pixels of the next frame
// LAUNCH | bus frozen, first held high for FIRST_CYCLES cycles
// WAIT   | waiting for net_done; result captured on it
module nn_frame_loader
    import nn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    nn_frame_loader_if.slave bus
);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [FC_W-1:0]  fc_cnt;
    logic             xfer, last_pix, frame_full, launch_fill, launch_wait;
    logic             s_ready_c, first_c, busy_c;
    logic [RES_W-1:0] res_data_q;
    logic             res_valid_q, frame_err_q;
    logic [BUS_W-1:0] frame_a;
`ifdef NN_FRAME_LOADER_DBUF_EN
    logic             sel, pend;
    logic [BUS_W-1:0] frame_b;
`endif

    assign xfer        = bus.s_valid && s_ready_c;
    assign last_pix    = (cnt == CNT_W'(IN_N - 1));
    assign frame_full  = xfer && last_pix;
    assign launch_fill = (state == FILL) && frame_full;
`ifdef NN_FRAME_LOADER_DBUF_EN
    // A frame finishing in the same cycle as net_done is relaunched rather than lost.
    assign launch_wait = (state == WAIT) && bus.net_done && (pend || frame_full);
`else
    assign launch_wait = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (launch_fill) state_nxt = LAUNCH;
            LAUNCH:  if (fc_cnt == '0) state_nxt = WAIT;
            WAIT: begin
                if (launch_wait) begin
                    state_nxt = LAUNCH;
                end else if (bus.net_done) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        s_ready_c = 1'b0;
        first_c   = 1'b0;
        busy_c    = 1'b0;
        case (state)
            FILL:   s_ready_c = !rst;
            LAUNCH: begin
                first_c = 1'b1;
                busy_c  = 1'b1;
            end
            WAIT: begin
                busy_c = 1'b1;
`ifdef NN_FRAME_LOADER_DBUF_EN
                s_ready_c = !rst && !pend;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            fc_cnt      <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (xfer) begin
                if (last_pix || bus.s_last) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // s_last must coincide exactly with the final pixel slot
                if (last_pix != bus.s_last) frame_err_q <= 1'b1;
            end
            if (launch_fill || launch_wait) begin
                fc_cnt <= FC_W'(FIRST_CYCLES - 1);
            end else if (state == LAUNCH && fc_cnt != '0) begin
                fc_cnt <= fc_cnt - 1'b1;
            end
            if (state == WAIT && bus.net_done) begin
                res_data_q  <= bus.net_result;
                res_valid_q <= 1'b1;
            end
        end
    end

`ifdef NN_FRAME_LOADER_DBUF_EN
    // sel names the buffer on in_bus; pixels always land in the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel  <= 1'b0;
            pend <= 1'b0;
        end else begin
            if (launch_fill || launch_wait) sel <= ~sel;
            if (launch_wait) begin
                pend <= 1'b0;
            end else if (state == WAIT && frame_full) begin
                pend <= 1'b1;
            end
        end
    end

    nn_frame_buf u_buf_a (
        .clk   (clk),
        .rst   (rst),
        .we    (xfer && sel),
        .idx   (cnt),
        .data  (bus.s_data),
        .frame (frame_a)
    );

    nn_frame_buf u_buf_b (
        .clk   (clk),
        .rst   (rst),
        .we    (xfer && !sel),
        .idx   (cnt),
        .data  (bus.s_data),
        .frame (frame_b)
    );

    assign bus.in_bus = sel ? frame_b : frame_a;
`else
    nn_frame_buf u_buf_a (
        .clk   (clk),
        .rst   (rst),
        .we    (xfer),
        .idx   (cnt),
        .data  (bus.s_data),
        .frame (frame_a)
    );

    assign bus.in_bus = frame_a;
`endif

    assign bus.s_ready   = s_ready_c;
    assign bus.first     = first_c;
    assign bus.busy      = busy_c;
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_nn_frame_loader.sv
// Bench for nn_frame_loader: directed frames against a frame/result queue model,
// with a per-cycle compare process plus literal spot checks.
module tb_nn_frame_loader;
    import nn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nn_frame_loader_if bus ();

    nn_frame_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DWIDTH-1:0] px [IN_N];
    int                mcnt      = 0;
    logic [BUS_W-1:0]  exp_frames[$];
    logic [RES_W-1:0]  exp_res[$];
    logic [BUS_W-1:0]  cur_bus   = '0;
    logic              exp_err   = 1'b0;
    logic              nd_expect = 1'b0;
    int                launches  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int k = 0; k < IN_N; k++) begin
                if (act[(IN_N-1-k)*DWIDTH +: DWIDTH] !== exp[(IN_N-1-k)*DWIDTH +: DWIDTH]) begin
                    $display("FAIL %s pixel=%0d actual=%0h required=%0h t=%0t", name, k,
                             act[(IN_N-1-k)*DWIDTH +: DWIDTH], exp[(IN_N-1-k)*DWIDTH +: DWIDTH], $time);
                    break;
                end
            end
        end
    endtask

    function automatic logic [BUS_W-1:0] pack_frame();
        logic [BUS_W-1:0] b;
        b = '0;
        for (int k = 0; k < IN_N; k++) b[(IN_N-1-k)*DWIDTH +: DWIDTH] = px[k];
        return b;
    endfunction

    // Frame rules: a frame is exactly IN_N words; a full frame always launches.
    task automatic model_accept(input logic [DWIDTH-1:0] d, input logic l);
        px[mcnt] = d;
        if (mcnt == IN_N - 1) begin
            exp_frames.push_back(pack_frame());
            if (!l) exp_err = 1'b1;
            mcnt = 0;
        end else if (l) begin
            exp_err = 1'b1;
            mcnt = 0;
        end else begin
            mcnt++;
        end
    endtask

    task automatic send_word(input logic [DWIDTH-1:0] d, input logic l, input int gap_pct);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc) begin
            @(negedge clk);
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = d;
                bus.s_last  = l;
                acc = bus.s_ready;
                if (acc) model_accept(d, l);
            end
            tries++;
            if (!acc && tries > 500) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=no_ready required=ready t=%0t", $time);
                return;
            end
        end
    endtask

    task automatic send_frame(input int n, input int last_at, input int kind, input int gap_pct);
        logic [DWIDTH-1:0] d;
        for (int k = 0; k < n; k++) begin
            case (kind)
                0:       d = DWIDTH'(k);
                1:       d = 16'hA000 ^ DWIDTH'(k);
                default: d = DWIDTH'($urandom);
            endcase
            send_word(d, k == last_at, gap_pct);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_net_wait();
        int n;
        n = 0;
        while (!(bus.busy && !bus.first) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout actual=busy%0b_first%0b required=busy1_first0", bus.busy, bus.first);
        end
    endtask

    task automatic pulse_done(input logic [RES_W-1:0] r);
        bus.net_done   = 1'b1;
        bus.net_result = r;
        nd_expect      = 1'b1;
        exp_res.push_back(r);
        @(negedge clk);
        bus.net_done = 1'b0;
        nd_expect    = 1'b0;
    endtask

    task automatic respond(input logic [RES_W-1:0] r, input int dly);
        wait_net_wait();
        repeat (dly) @(negedge clk);
        pulse_done(r);
    endtask

    // Per-cycle compare, sampled 2 time units after the active edge.
    initial begin
        bit pf;
        int frun;
        pf   = 1'b0;
        frun = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                pf   = 1'b0;
                frun = 0;
            end else begin
                if (bus.first && !pf) begin
                    launches++;
                    if (exp_frames.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL launch_unexpected actual=first required=no_first t=%0t", $time);
                    end else begin
                        cur_bus = exp_frames.pop_front();
                    end
                end
                if (bus.first) begin
                    frun++;
                end else if (pf) begin
                    chk("first_len", frun, FIRST_CYCLES);
                    frun = 0;
                end
                pf = bus.first;
                if (bus.busy) chk_bus("in_bus_hold", bus.in_bus, cur_bus);
                chk("res_valid", bus.res_valid, nd_expect);
                if (bus.res_valid) begin
                    if (exp_res.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL res_unexpected actual=%0h required=none", bus.res_data);
                    end else begin
                        chk("res_data", bus.res_data, exp_res.pop_front());
                    end
                end
                chk("frame_err", bus.frame_err, exp_err);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        bus.s_data     = '0;
        bus.s_valid    = 1'b0;
        bus.s_last     = 1'b0;
        bus.net_done   = 1'b0;
        bus.net_result = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_first", bus.first, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk_bus("rst_in_bus", bus.in_bus, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.s_ready, 1);

        // frame 0x0000..0x030F
        send_frame(IN_N, IN_N - 1, 0, 0);
        chk("f1_first_c1", bus.first, 1);
        chk("f1_busy", bus.busy, 1);
        chk("f1_ready_low", bus.s_ready, 0);
        chk("f1_pix0", bus.in_bus[BUS_W-1 -: DWIDTH], 16'h0000);
        chk("f1_pix783", bus.in_bus[DWIDTH-1:0], 16'h030F);
        chk("f1_pix1", bus.in_bus[BUS_W-DWIDTH-1 -: DWIDTH], 16'h0001);
        @(negedge clk);
        chk("f1_first_c2", bus.first, 1);
        @(negedge clk);
        chk("f1_first_c3", bus.first, 0);
        chk("f1_busy_wait", bus.busy, 1);
        respond(4'd7, 3);
        chk("f1_res_valid", bus.res_valid, 1);
        chk("f1_res_data", bus.res_data, 4'd7);
        chk("f1_ready_back", bus.s_ready, 1);
        chk("f1_busy_low", bus.busy, 0);
        @(negedge clk);
        chk("f1_res_valid_drop", bus.res_valid, 0);

        // early s_last at pixel 100
        l0 = launches;
        send_frame(101, 100, 1, 0);
        chk("short_err", bus.frame_err, 1);
        chk("short_no_first", bus.first, 0);
        chk("short_ready", bus.s_ready, 1);
        repeat (3) @(negedge clk);
        chk("short_no_launch", launches - l0, 0);
        send_frame(IN_N, IN_N - 1, 1, 0);
        chk("after_short_first", bus.first, 1);
        chk("after_short_pix783", bus.in_bus[DWIDTH-1:0], 16'hA30F);
        respond(4'd3, 10);

        // ten frames with 50% valid gaps, results 0..9
        l0 = launches;
        for (int f = 0; f < 10; f++) begin
            send_frame(IN_N, IN_N - 1, 2, 50);
            respond(RES_W'(f), $urandom_range(0, 15));
        end
        chk("gap_launches", launches - l0, 10);

        // reset during WAIT, net_done the cycle after
        send_frame(IN_N, IN_N - 1, 1, 0);
        wait_net_wait();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_s_ready", bus.s_ready, 0);
        chk("rst_wait_first", bus.first, 0);
        exp_frames.delete();
        exp_res.delete();
        cur_bus = '0;
        exp_err = 1'b0;
        mcnt    = 0;
        rst = 1'b0;
        bus.net_done   = 1'b1;
        bus.net_result = 4'd9;
        nd_expect      = 1'b0;
        @(negedge clk);
        bus.net_done = 1'b0;
        chk("post_rst_res_valid", bus.res_valid, 0);
        chk("post_rst_res_data", bus.res_data, 0);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_first", bus.first, 0);
        chk("post_rst_ready", bus.s_ready, 1);
        chk("post_rst_err", bus.frame_err, 0);
        chk_bus("post_rst_in_bus", bus.in_bus, '0);

        // full-length frame without s_last still launches and flags the error
        send_frame(IN_N, -1, 2, 0);
        chk("nolast_first", bus.first, 1);
        chk("nolast_err", bus.frame_err, 1);
        respond(4'd11, 2);
        send_frame(IN_N, IN_N - 1, 0, 20);
        respond(4'd2, 1);

`ifdef NN_FRAME_LOADER_DBUF_EN
        send_frame(IN_N, IN_N - 1, 0, 0);
        wait_net_wait();
        chk("dbuf_ready_in_wait", bus.s_ready, 1);
        send_frame(IN_N, IN_N - 1, 1, 0);
        chk("dbuf_ready_hold", bus.s_ready, 0);
        chk("dbuf_still_wait", bus.busy, 1);
        chk("dbuf_no_first", bus.first, 0);
        chk("dbuf_old_pix783", bus.in_bus[DWIDTH-1:0], 16'h030F);
        pulse_done(4'd5);
        chk("dbuf_swap_res_valid", bus.res_valid, 1);
        chk("dbuf_swap_first", bus.first, 1);
        chk("dbuf_swap_pix783", bus.in_bus[DWIDTH-1:0], 16'hA30F);
        respond(4'd6, 2);
`endif

        repeat (3) @(negedge clk);
        chk("frames_drained", exp_frames.size(), 0);
        chk("results_drained", exp_res.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
